aes_cipher_iter: RTL

- Iterative AES encryption datapath that consumes the flat round-key bus produced by the key-expansion stage.
- Encrypts one 128-bit block per transaction, performing one full round per clock cycle.
- Sits directly downstream of key expansion and upstream of the block-output/mode logic.
- Uses a valid/ready handshake on both input and output.

---
 rtl/aes_cipher_iter_if.sv | 31 +++
 rtl/aes_cipher_iter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_iter_if.sv
// rtl/aes_cipher_iter_if.sv - handshake and data bundle for the iterative AES cipher
// Parameters: NK key words (4/6/8); KW derived round-key bus width.
// Signals:
//   in_valid/in_ready/in_data     plaintext block handshake, [0:127] FIPS-197 byte order
//   round_keys                    flat expanded schedule, round key r at [128r +: 128]
//   out_valid/out_ready/out_data  ciphertext handshake, same byte order
//   busy                          cipher is not idle
// Modports: master drives plaintext/keys and accepts ciphertext; slave is the cipher.
interface aes_cipher_iter_if #(
  parameter int NK = 8,
  parameter int KW = 4 * (NK + 7) * 32
);
  logic          in_valid;
  logic          in_ready;
  logic [0:127]  in_data;
  logic [0:KW-1] round_keys;
  logic          out_valid;
  logic          out_ready;
  logic [0:127]  out_data;
  logic          busy;

  modport master (
    output in_valid, in_data, round_keys, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, round_keys, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_cipher_iter.sv
// rtl/aes_cipher_iter.sv - iterative AES encryption, one full round per clock
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    aes_cipher_iter_if.slave (in_valid/in_ready/in_data, round_keys,
//          out_valid/out_ready/out_data, busy)
// Optional: define AES_KEY_LATCH_EN to capture round_keys on the accept edge so
// upstream may change the key right after accept; otherwise the live bus is used
// every round and must be held stable until the last round.
module aes_cipher_iter #(
  parameter int NK = 8,
  parameter int KW = 4 * (NK + 7) * 32
) (
  input logic              clk,
  input logic              rst_n,
  aes_cipher_iter_if.slave bus
);

  localparam int         NR  = NK + 6;
  localparam logic [3:0] NR4 = 4'(NR);

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic [3:0]   rnd;
  logic [0:127] state_reg;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         busy_r;

  logic [0:KW-1] sched;
  logic [3:0]    rk_idx;
  logic [0:127]  round_key;
  logic [0:127]  round_out;
  logic          accept;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[8 * (255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes -> ShiftRows -> MixColumns (skipped on the last round) -> AddRoundKey.
  // Byte i of the block is row i%4, column i/4.
  function automatic logic [0:127] aes_round(input logic [0:127] s,
                                             input logic [0:127] rk,
                                             input logic         last);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] mc;
    mc = '0;
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(s[8*i +: 8]);
    end
    // Row r rotates left by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c + r] = sb[4*((c + r) % 4) + r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c + 1];
      a2 = sr[4*c + 2];
      a3 = sr[4*c + 3];
      if (last) begin
        mc[32*c +: 32] = {a0, a1, a2, a3};
      end else begin
        mc[32*c +: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                          a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                          a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                          xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return mc ^ rk;
  endfunction

  assign accept = (state == IDLE) && bus.in_valid && in_ready_r;

`ifdef AES_KEY_LATCH_EN
  // Round 0 is applied from the live bus on the accept edge; this copy feeds rounds 1..NR.
  logic [0:KW-1] key_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg <= '0;
    end else if (accept) begin
      key_reg <= bus.round_keys;
    end
  end

  assign sched = key_reg;
`else
  assign sched = bus.round_keys;
`endif

  // Clamp keeps the key select in range even if rnd is ever corrupted; the FSM
  // discards such a cycle anyway.
  assign rk_idx    = (rnd > NR4) ? NR4 : rnd;
  assign round_key = sched[128 * int'(rk_idx) +: 128];
  assign round_out = aes_round(state_reg, round_key, rnd == NR4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rnd         <= '0;
      state_reg   <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid_r <= 1'b0;
          if (accept) begin
            state_reg  <= bus.in_data ^ bus.round_keys[0:127];
            rnd        <= 4'd1;
            state      <= RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end
        end
        RUN: begin
          if (rnd == 4'd0 || rnd > NR4) begin
            state      <= IDLE;
            rnd        <= '0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end else begin
            state_reg <= round_out;
            if (rnd == NR4) begin
              state       <= DONE;
              rnd         <= '0;
              out_valid_r <= 1'b1;
            end else begin
              rnd <= rnd + 4'd1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          rnd         <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = state_reg;
  assign bus.busy      = busy_r;

endmodule
